// File: rtl/nabp_sinogram_loader.sv
// rtl/nabp_sinogram_loader.sv - streams a host sinogram into sinogram RAM, then kicks the NABP core and reports completion
module nabp_sinogram_loader #(
    parameter int DATA_WIDTH   = 12,
    parameter int ANGLE_WIDTH  = 7,
    parameter int SHIFT_WIDTH  = 8,
    parameter int NO_OF_ANGLES = 128,
    parameter int NO_OF_SHIFTS = 256
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              host_start,
    input  logic [DATA_WIDTH-1:0]             host_val,
    input  logic                              host_valid,
    output logic                              host_ready,
    output logic                              ram_we,
    output logic [ANGLE_WIDTH+SHIFT_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0]             ram_wdata,
    output logic                              nabp_kick,
    input  logic                              nabp_done,
    output logic                              busy,
    output logic                              done
);

    localparam logic [ANGLE_WIDTH-1:0] ANGLE_LAST = ANGLE_WIDTH'(NO_OF_ANGLES - 1);
    localparam logic [SHIFT_WIDTH-1:0] SHIFT_LAST = SHIFT_WIDTH'(NO_OF_SHIFTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_KICK,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [ANGLE_WIDTH-1:0]   angle_q;
    logic [SHIFT_WIDTH-1:0]   shift_q;
    logic                     handshake;
    logic                     last_shift;
    logic                     last_sample;

    // host_ready is only ever high in LOAD; the state term keeps the handshake self-evidently local
    assign handshake   = (state_q == S_LOAD) && host_valid && host_ready;
    assign last_shift  = (shift_q == SHIFT_LAST);
    assign last_sample = last_shift && (angle_q == ANGLE_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (host_start) state_d = S_LOAD;
            S_LOAD:   if (handshake && last_sample) state_d = S_FLUSH;
            S_FLUSH:  state_d = S_KICK;
            S_KICK:   state_d = S_WAIT;
            S_WAIT:   if (nabp_done) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            host_ready <= 1'b0;
            nabp_kick  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            host_ready <= (state_d == S_LOAD);
            nabp_kick  <= (state_d == S_KICK);
            done       <= (state_d == S_FINISH);
            busy       <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            angle_q   <= '0;
            shift_q   <= '0;
        end else begin
            ram_we <= handshake;
            if (handshake) begin
                ram_waddr <= {angle_q, shift_q};
                ram_wdata <= host_val;
            end
            if (state_q == S_IDLE && host_start) begin
                angle_q <= '0;
                shift_q <= '0;
            end else if (handshake) begin
                if (last_shift) begin
                    shift_q <= '0;
                    angle_q <= last_sample ? '0 : angle_q + ANGLE_WIDTH'(1);
                end else begin
                    shift_q <= shift_q + SHIFT_WIDTH'(1);
                end
            end
        end
    end

endmodule
